// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a req/ready
// handshake and holds the fetched word in the IF/ID register for decode.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] address,
    output logic [31:0] PC_4,
    output logic        instr_valid,
    output logic [15:0] fetch_count,
    output logic        misalign_err
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ld;

    // A held instruction that decode cannot take blocks the next request.
    assign imem_req  = (state == FETCH) && !(instr_valid && stall);
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign ld        = imem_req && imem_ready && !jump_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            address      <= NOP_WORD;
            PC_4         <= 32'h0000_0000;
            instr_valid  <= 1'b0;
            fetch_count  <= 16'h0000;
            misalign_err <= 1'b0;
        end else begin
            state <= FETCH;
            if (jump_en) begin
                // Redirect wins over stall and discards any same-cycle response.
                pc          <= jump_addr & 32'hFFFF_FFFC;
                instr_valid <= 1'b0;
                address     <= NOP_WORD;
                if (jump_addr[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else if (ld) begin
                address     <= imem_rdata;
                PC_4        <= pc_plus4;
                instr_valid <= 1'b1;
                pc          <= pc_plus4;
                fetch_count <= fetch_count + 16'd1;
            end else if (instr_valid && !stall) begin
                instr_valid <= 1'b0;
                address     <= NOP_WORD;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus randomized
// stall/jump/wait-state traffic checked against a transaction-level model.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] address;
    logic [31:0] PC_4;
    logic        instr_valid;
    logic [15:0] fetch_count;
    logic        misalign_err;

    instr_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .address     (address),
        .PC_4        (PC_4),
        .instr_valid (instr_valid),
        .fetch_count (fetch_count),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model of the architectural state
    logic [31:0] m_pc, m_word, m_pc4;
    logic        m_valid, m_started, m_mis;
    logic [15:0] m_cnt;

    // memory model
    int waits = 0;
    int mem_cnt = 0;
    bit force_ready = 0;
    bit spurious = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_word = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_started = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
        mem_cnt = 0;
    endtask

    task automatic check_all(input logic exp_req);
        chk("imem_req",     {31'b0, imem_req},     {31'b0, exp_req});
        chk("imem_addr",    imem_addr,             m_pc);
        chk("address",      address,               m_word);
        chk("PC_4",         PC_4,                  m_pc4);
        chk("instr_valid",  {31'b0, instr_valid},  {31'b0, m_valid});
        chk("fetch_count",  {16'b0, fetch_count},  {16'b0, m_cnt});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic tick();
        logic exp_req, ld;
        #1;
        exp_req = m_started && !(m_valid && stall);
        if (imem_req && mem_cnt >= waits) begin
            imem_ready = 1'b1;
            imem_rdata = imem_addr | 32'hA000_0000;
        end else begin
            imem_ready = force_ready || (!imem_req && spurious && $urandom_range(0, 3) == 0);
            imem_rdata = force_ready ? (imem_addr | 32'hA000_0000) : $urandom();
        end
        #1;
        check_all(exp_req);
        @(posedge clk);
        ld = exp_req && imem_ready && !jump_en;
        if (jump_en) begin
            m_pc = {jump_addr[31:2], 2'b00};
            m_valid = 1'b0;
            m_word = 32'h0;
            if (jump_addr[1:0] != 2'b00) m_mis = 1'b1;
        end else if (ld) begin
            m_word = imem_rdata;
            m_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt = m_cnt + 16'd1;
        end else if (m_valid && !stall) begin
            m_valid = 1'b0;
            m_word = 32'h0;
        end
        m_started = 1'b1;
        if (!exp_req || jump_en || imem_ready) mem_cnt = 0;
        else mem_cnt++;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] saved_cnt;
        rst_n = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all(1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // zero-wait streaming: IDLE cycle then one word per cycle
        tick();
        tick(); tick(); tick();
        chk("t1_address", address, 32'hA000_0008);
        chk("t1_pc4", PC_4, 32'd12);
        chk("t1_count", {16'b0, fetch_count}, 32'd3);

        // stall while holding the word from pc=8
        stall = 1'b1;
        repeat (4) tick();
        chk("t3_frozen_addr", address, 32'hA000_0008);
        chk("t3_frozen_pc4", PC_4, 32'd12);
        stall = 1'b0;
        tick();
        chk("t3_resume_word", address, 32'hA000_000C);

        // 2-wait-state memory
        waits = 2;
        repeat (9) tick();

        // jump collides with stall and a same-cycle ready
        waits = 0;
        tick();
        stall = 1'b1; force_ready = 1'b1; jump_en = 1'b1; jump_addr = 32'h0000_0100;
        saved_cnt = m_cnt;
        tick();
        jump_en = 1'b0; force_ready = 1'b0;
        chk("t4_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4_nop", address, 32'h0);
        chk("t4_addr", imem_addr, 32'h100);
        chk("t4_count", {16'b0, fetch_count}, {16'b0, saved_cnt});
        stall = 1'b0;
        tick();
        chk("t4_pc4", PC_4, 32'h104);

        // misaligned jump then a normal one
        jump_en = 1'b1; jump_addr = 32'h0000_0203;
        tick();
        jump_en = 1'b0;
        chk("t5_pc", imem_addr, 32'h200);
        chk("t5_mis", {31'b0, misalign_err}, 32'd1);
        repeat (2) tick();
        jump_en = 1'b1; jump_addr = 32'h0000_0300;
        tick();
        jump_en = 1'b0;
        chk("t5_sticky", {31'b0, misalign_err}, 32'd1);

        // PC wraps at the top of the address space
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
        tick();
        jump_en = 1'b0;
        tick();
        chk("t6_pc4_wrap", PC_4, 32'h0);
        chk("t6_addr_wrap", imem_addr, 32'h0);

        // randomized traffic
        spurious = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) waits = $urandom_range(0, 2);
            stall = ($urandom_range(0, 3) == 0);
            jump_en = ($urandom_range(0, 19) == 0);
            jump_addr = $urandom();
            tick();
        end
        spurious = 1'b0; stall = 1'b0; jump_en = 1'b0; waits = 0;

        // run fetch_count up to its wrap point
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) tick();
        chk("t6_count_max", {16'b0, fetch_count}, 32'h0000_FFFF);
        tick();
        chk("t6_count_wrap", {16'b0, fetch_count}, 32'h0);

        // asynchronous reset while a request is waiting
        waits = 2;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        waits = 0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
